// File: rtl/uart_rx_buffer_pkg.sv
// uart_rx_buffer shared package
// Default sizing and width helpers for the receive buffer and its FIFO.
package uart_rx_buffer_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_DEPTH = 4;

    // Pointer width; a single-entry FIFO would still need one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy must be able to represent Depth itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers wrap by natural overflow, so Depth must be a power of two.
    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// uart_rx_buffer bus interface
// Deserializer input, output stream and status bundled together.
interface uart_rx_buffer_if
    import uart_rx_buffer_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int Depth = DEF_DEPTH
) ();

    localparam int CW = cnt_w(Depth);

    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic          overrun_clear;
    logic [CW-1:0] count;

    modport master (
        output rx_data,
        output rx_valid,
        output out_ready,
        output overrun_clear,
        input  out_data,
        input  out_valid,
        input  overrun,
        input  count
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  out_ready,
        input  overrun_clear,
        output out_data,
        output out_valid,
        output overrun,
        output count
    );

endinterface

// File: rtl/uart_rx_buffer_sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO
// Head word is read combinationally; a pop on a full FIFO frees room for a push.
module sync_fifo_fwft
    import uart_rx_buffer_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int Depth = DEF_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic                     full,
    output logic [cnt_w(Depth)-1:0]  count
);

    localparam int PW = ptr_w(Depth);
    localparam int CW = cnt_w(Depth);

    if (!depth_ok(Depth)) begin : g_bad_depth
        $error("sync_fifo_fwft: Depth must be a power of two >= 2");
    end

    logic [W-1:0]  r_mem [Depth];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(Depth));
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    // Storage write; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: frame capture from the deserializer into a FWFT FIFO
// Rising edge of rx_valid pushes one word; drops on full set a sticky flag.
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int Depth = DEF_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    uart_rx_buffer_if.slave   bus
);

    localparam int CW = cnt_w(Depth);

    logic          r_prev_valid;
    logic          r_overrun;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic          w_drop;
    logic [W-1:0]  w_head;
    logic [CW-1:0] w_count;

    assign w_push = bus.rx_valid & ~r_prev_valid;
    assign w_pop  = bus.out_ready & ~w_empty;
    assign w_drop = w_push & w_full & ~w_pop;

    // Previous rx_valid; starts high so a frame already good at reset is ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_valid <= 1'b1;
        end else begin
            r_prev_valid <= bus.rx_valid;
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (bus.overrun_clear) begin
            r_overrun <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .W     (W),
        .Depth (Depth)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (bus.rx_data),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full),
        .count     (w_count)
    );

    assign bus.out_data  = w_head;
    assign bus.out_valid = ~w_empty;
    assign bus.overrun   = r_overrun;
    assign bus.count     = w_count;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: scoreboard bench for uart_rx_buffer
// Stimulus queues expected words; a negedge monitor checks every pop.
module tb_uart_rx_buffer;

    logic clock;
    logic reset;

    uart_rx_buffer_if #(.W(8), .Depth(4)) bus ();

    uart_rx_buffer #(
        .W     (8),
        .Depth (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] exp_q [$];
    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head word must match the queue front.
    always @(negedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none",
                         bus.out_data);
            end else begin
                chk("pop_data", {24'd0, bus.out_data}, {24'd0, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One deserializer frame: rx_valid low for a cycle, then high (left high).
    task automatic frame(input logic [7:0] d, input bit accept);
        bus.rx_valid = 1'b0;
        tick();
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        if (accept) exp_q.push_back(d);
        tick();
    endtask

    task automatic drain(input int n);
        bus.out_ready = 1'b1;
        repeat (n) tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset             = 1'b1;
        bus.rx_data       = 8'h00;
        bus.rx_valid      = 1'b0;
        bus.out_ready     = 1'b0;
        bus.overrun_clear = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_count", {29'd0, bus.count}, 32'd0);
        chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);

        // Single frame, then a long level high adds nothing.
        frame(8'hA5, 1'b1);
        chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("single_data", {24'd0, bus.out_data}, 32'hA5);
        chk("single_count", {29'd0, bus.count}, 32'd1);
        repeat (100) tick();
        chk("hold_count", {29'd0, bus.count}, 32'd1);
        drain(1);
        chk("single_drained", {29'd0, bus.count}, 32'd0);

        // Ordering across pointer wrap.
        for (int i = 1; i <= 10; i++) begin
            frame(i[7:0], 1'b1);
            if (i % 2 == 0) drain(2);
        end
        chk("wrap_count", {29'd0, bus.count}, 32'd0);
        chk("wrap_overrun", {31'd0, bus.overrun}, 32'd0);

        // Overrun on the fifth word.
        for (int i = 0; i < 5; i++) begin
            frame(8'h10 + i[7:0], i < 4);
        end
        chk("ovr_count", {29'd0, bus.count}, 32'd4);
        chk("ovr_flag", {31'd0, bus.overrun}, 32'd1);
        drain(4);
        chk("ovr_drained", {29'd0, bus.count}, 32'd0);
        chk("ovr_sticky", {31'd0, bus.overrun}, 32'd1);
        bus.overrun_clear = 1'b1;
        tick();
        bus.overrun_clear = 1'b0;
        chk("ovr_cleared", {31'd0, bus.overrun}, 32'd0);

        // Full FIFO with push and pop in the same cycle.
        for (int i = 0; i < 4; i++) frame(8'h20 + i[7:0], 1'b1);
        bus.rx_valid = 1'b0;
        tick();
        bus.rx_data   = 8'h55;
        bus.rx_valid  = 1'b1;
        bus.out_ready = 1'b1;
        exp_q.push_back(8'h55);
        tick();
        bus.out_ready = 1'b0;
        chk("pp_count", {29'd0, bus.count}, 32'd4);
        chk("pp_overrun", {31'd0, bus.overrun}, 32'd0);
        drain(4);
        chk("pp_drained", {29'd0, bus.count}, 32'd0);

        // Drop and clear in the same cycle: set wins.
        for (int i = 0; i < 4; i++) frame(8'h30 + i[7:0], 1'b1);
        bus.rx_valid = 1'b0;
        tick();
        bus.rx_data       = 8'h34;
        bus.rx_valid      = 1'b1;
        bus.overrun_clear = 1'b1;
        tick();
        bus.overrun_clear = 1'b0;
        chk("race_overrun", {31'd0, bus.overrun}, 32'd1);
        drain(4);
        bus.overrun_clear = 1'b1;
        tick();
        bus.overrun_clear = 1'b0;

        // Reset mid-stream while rx_valid is high.
        for (int i = 0; i < 3; i++) frame(8'h40 + i[7:0], 1'b1);
        chk("mid_count", {29'd0, bus.count}, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        tick();
        chk("mrst_count", {29'd0, bus.count}, 32'd0);
        chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mrst_overrun", {31'd0, bus.overrun}, 32'd0);
        repeat (5) tick();
        chk("mrst_nocapture", {29'd0, bus.count}, 32'd0);
        frame(8'h43, 1'b1);
        chk("mrst_recapture", {29'd0, bus.count}, 32'd1);
        chk("mrst_data", {24'd0, bus.out_data}, 32'h43);
        drain(1);

        bus.rx_valid = 1'b0;
        tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("final_count", {29'd0, bus.count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side buffer placed directly downstream of the UART deserializer inside the receiver path. It detects completion of each frame from the deserializer's level-type `valid`, captures the received word into a small first-word-fall-through FIFO, and presents it to the system on a ready/valid stream. Frames arriving while the FIFO is full are dropped and flagged by a sticky overrun bit.

## Interface
- `W`, 8, data word width; must match the deserializer's `W`.
- `Depth`, 4, FIFO depth in words; power of two, ≥ 2.
- `clock`  input  1  single clock, rising edge; the deserializer runs on the same clock.
- `reset`  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `rx_data`  input  W  word from the deserializer; stable while `rx_valid` is high.
- `rx_valid`  input  1  deserializer frame-good level; rises when the stop bit is sampled high and falls on the next start bit.
- `out_data`  output  W  head-of-FIFO word; meaningful only when `out_valid`=1.
- `out_valid`  output  1  FIFO not empty.
- `out_ready`  input  1  consumer accepts the head word this cycle.
- `overrun`  output  1  sticky: at least one frame was dropped because the FIFO was full.
- `overrun_clear`  input  1  clears `overrun`.
- `count`  output  $clog2(Depth+1)  words currently stored.

## Operation
- Frame detect: the `prev_valid` register samples `rx_valid` each cycle. Push request `push = rx_valid & !prev_valid` (one-cycle pulse per frame). `prev_valid` resets to 1, so a frame that completed before reset is not captured.
- Pop: `pop = out_valid & out_ready`.
- FIFO: `rd_ptr` and `wr_ptr` are $clog2(Depth) bits and wrap modulo Depth. `count` is tracked separately. `out_valid = (count != 0)`. `out_data = mem[rd_ptr]`, combinational read (FWFT).
- Push when `count < Depth`: write `rx_data` to `mem[wr_ptr]`, increment `wr_ptr`.
- Push when `count == Depth` and no pop the same cycle: word discarded, `overrun` ← 1, pointers unchanged.
- Simultaneous push and pop:
  - When full: the pop frees a slot, so the push is accepted, `count` is unchanged, and `overrun` is not set.
  - When empty: the push is accepted and the pop is ignored, since `out_valid` was 0.
- `count` next value = `count` + accepted push − pop.
- `overrun`:
  - If set and clear occur in the same cycle, set wins.
  - Otherwise `overrun_clear` drives it to 0.
- `out_ready` while empty has no effect.
- Reset values: `rd_ptr`, `wr_ptr` = 0; `count` = 0; `out_valid` = 0; `overrun` = 0; `prev_valid` = 1. `mem` is not reset, so `out_data` is X/don't-care while `out_valid`=0.
- Reset mid-operation: all stored words are discarded. A deserializer frame whose `rx_valid` is already high at reset release is not captured.

## Timing
- Push latency: `rx_valid` rises in cycle N. The word is written at the end of N, and `out_valid`/`out_data` reflect it in N+1 if the FIFO was empty.
- Pop: the head is consumed at the edge ending the cycle in which `out_valid & out_ready` holds. The next word appears in the following cycle, with no bubble.
- Throughput: one push and one pop per cycle. Frame spacing from the deserializer is far larger than this.
- `overrun` asserts in the cycle after the dropped push.

## Structure
- Shared package holds:
  - Derived width constants: pointer width = $clog2(Depth), count width = $clog2(Depth+1).
  - A parameter check that `Depth` is a power of two ≥ 2.
- Sub-module `sync_fifo_fwft` (parameters `W`, `Depth`; ports `clock`, `reset`, `push`, `push_data`, `pop`, `head`, `empty`, `full`, `count`) holds the storage and pointers. It is reusable on the transmit side.
- `uart_rx_buffer` itself holds only the edge detect, the overrun logic, and the port mapping.

## Test plan
- Single frame: `rx_valid` rises with `rx_data`=0xA5, `out_ready`=0 → `out_valid`=1 and `out_data`=0xA5 next cycle, `count`=1; holding `rx_valid` high 100 cycles adds no further words.
- Ordering and wrap: push 0x01..0x0A with `out_ready` asserted after every 2 pushes (Depth=4) → output stream exactly 0x01..0x0A, pointers wrap with no loss, `overrun`=0.
- Overrun: `out_ready`=0, push 0x10,0x11,0x12,0x13,0x14 → `count`=4, `overrun`=1, head sequence on drain 0x10..0x13; `overrun_clear` pulse → `overrun`=0.
- Full with simultaneous push/pop: FIFO full, `out_ready`=1 on the cycle `rx_valid` rises with 0x55 → `count` stays 4, `overrun`=0, 0x55 is the last word drained.
- Set/clear race: overflowing push in the same cycle as `overrun_clear`=1 → `overrun`=1.
- Reset mid-stream: 3 words stored, `reset` pulsed while `rx_valid` is high → `count`=0, `out_valid`=0; no word captured until `rx_valid` falls and rises again.
